// File: rtl/hazard_control.sv
// RAW hazard stall and branch-misprediction control for the 16-bit pipelined core.
// Optional HC_DEBUG_EN exposes destination registers and hit vectors on debug1..debug4.
module hazard_control (
    input  logic        clock,
    input  logic        reset,
    output logic        MP,
    output logic        PCStall,
    input  logic [15:0] IFID,
    input  logic [15:0] IDEX,
    input  logic [15:0] EXMEM,
    input  logic        EXMEMWrite,
    input  logic        EXMEMRegDst,
    input  logic        IDEXWrite,
    input  logic        IDEXRegDst,
    input  logic        PCSrc,
    input  logic        Predict,
    output logic [3:0]  code,
    input  logic        negclock,
    output logic [2:0]  debug1,
    output logic [2:0]  debug2,
    output logic [2:0]  debug3,
    output logic [2:0]  debug4
);

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] code_q, code_d;

    logic [2:0] ifid_rs, ifid_rt;
    logic [2:0] idex_dst, exmem_dst;
    logic       idex_valid, exmem_valid;
    logic       idex_rs_hit, idex_rt_hit, exmem_rs_hit, exmem_rt_hit;
    logic       raw_idex, raw_exmem, mis, in_recover;

    // Only the register fields take part in the comparison; the rest is ignored.
    logic unused_bits;
    assign unused_bits = ^{negclock, IFID[15:13], IFID[6:0],
                           IDEX[15:10], IDEX[3:0], EXMEM[15:10], EXMEM[3:0]};

    always_comb begin
        ifid_rs      = IFID[12:10];
        ifid_rt      = IFID[9:7];
        idex_dst     = IDEXRegDst  ? IDEX[6:4]  : IDEX[9:7];
        exmem_dst    = EXMEMRegDst ? EXMEM[6:4] : EXMEM[9:7];
        idex_valid   = IDEXWrite  && (idex_dst  != 3'd0);
        exmem_valid  = EXMEMWrite && (exmem_dst != 3'd0);
        idex_rs_hit  = idex_valid  && (idex_dst  == ifid_rs);
        idex_rt_hit  = idex_valid  && (idex_dst  == ifid_rt);
        exmem_rs_hit = exmem_valid && (exmem_dst == ifid_rs);
        exmem_rt_hit = exmem_valid && (exmem_dst == ifid_rt);
        raw_idex     = idex_rs_hit  || idex_rt_hit;
        raw_exmem    = exmem_rs_hit || exmem_rt_hit;
        mis          = PCSrc ^ Predict;
        in_recover   = (state_q == RECOVER);
    end

    // Wrong-path instructions are being flushed in RECOVER, so neither flag may fire there.
    always_comb begin
        MP      = 1'b0;
        PCStall = 1'b0;
        if (reset && !in_recover) begin
            MP      = mis;
            PCStall = (raw_idex || raw_exmem) && !mis;
        end
    end

    always_comb begin
        state_d = NORMAL;
        if (!in_recover && mis)
            state_d = RECOVER;

        code_d = 4'd0;
        if (in_recover)
            code_d = 4'd9;
        else if (mis)
            code_d = 4'd8;
        else if (idex_rs_hit)
            code_d = 4'd1;
        else if (idex_rt_hit)
            code_d = 4'd2;
        else if (exmem_rs_hit)
            code_d = 4'd3;
        else if (exmem_rt_hit)
            code_d = 4'd4;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= NORMAL;
            code_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    assign code = code_q;

`ifdef HC_DEBUG_EN
    assign debug1 = exmem_dst;
    assign debug2 = idex_dst;
    assign debug3 = {idex_valid, idex_rs_hit, idex_rt_hit};
    assign debug4 = {exmem_valid, exmem_rs_hit, exmem_rt_hit};
`else
    assign debug1 = 3'd0;
    assign debug2 = 3'd0;
    assign debug3 = 3'd0;
    assign debug4 = 3'd0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Table-driven bench for hazard_control with a scoreboard queue for the one-cycle-late code output.
// Debug taps are checked against real values only when HC_DEBUG_EN is defined.
module tb_hazard_control;

    logic        clock = 1'b0;
    logic        reset;
    logic        MP, PCStall;
    logic [15:0] IFID, IDEX, EXMEM;
    logic        EXMEMWrite, EXMEMRegDst, IDEXWrite, IDEXRegDst;
    logic        PCSrc, Predict;
    logic [3:0]  code;
    logic        negclock;
    logic [2:0]  debug1, debug2, debug3, debug4;

    int errors = 0;
    int checks = 0;
    int code_sb[$];

    typedef struct {
        logic        rst_n;
        logic [15:0] ifid, idex, exmem;
        logic        idex_w, idex_rd, exmem_w, exmem_rd;
        logic        pcsrc, predict;
        logic        exp_stall, exp_mp;
        logic [3:0]  exp_code;
        logic        chk_idex_dbg, chk_exmem_dbg;
        logic [2:0]  exp_d1, exp_d2, exp_d3, exp_d4;
    } vec_t;

    vec_t vecs[11];

    hazard_control dut (
        .clock       (clock),
        .reset       (reset),
        .MP          (MP),
        .PCStall     (PCStall),
        .IFID        (IFID),
        .IDEX        (IDEX),
        .EXMEM       (EXMEM),
        .EXMEMWrite  (EXMEMWrite),
        .EXMEMRegDst (EXMEMRegDst),
        .IDEXWrite   (IDEXWrite),
        .IDEXRegDst  (IDEXRegDst),
        .PCSrc       (PCSrc),
        .Predict     (Predict),
        .code        (code),
        .negclock    (negclock),
        .debug1      (debug1),
        .debug2      (debug2),
        .debug3      (debug3),
        .debug4      (debug4)
    );

    always #5 clock = ~clock;
    assign negclock = ~clock;

    function automatic logic [2:0] dbg(input logic [2:0] v);
`ifdef HC_DEBUG_EN
        return v;
`else
        return (v & 3'd0);
`endif
    endfunction

    // ctl = {IDEXWrite, IDEXRegDst, EXMEMWrite, EXMEMRegDst}; no misprediction, reset released.
    function automatic vec_t mk(input logic [15:0] ifid, input logic [15:0] idex,
                                input logic [15:0] exmem, input logic [3:0] ctl,
                                input logic stall, input logic [3:0] c);
        vec_t v;
        v.rst_n = 1'b1;
        v.ifid = ifid;
        v.idex = idex;
        v.exmem = exmem;
        {v.idex_w, v.idex_rd, v.exmem_w, v.exmem_rd} = ctl;
        v.pcsrc = 1'b0;
        v.predict = 1'b0;
        v.exp_stall = stall;
        v.exp_mp = 1'b0;
        v.exp_code = c;
        v.chk_idex_dbg = 1'b0;
        v.chk_exmem_dbg = 1'b0;
        v.exp_d1 = 3'd0;
        v.exp_d2 = 3'd0;
        v.exp_d3 = 3'd0;
        v.exp_d4 = 3'd0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive at the falling edge, check combinational outputs, then compare code after the rising edge.
    task automatic applyStimulus(input vec_t v, input string name);
        int exp_code;
        @(negedge clock);
        reset       = v.rst_n;
        IFID        = v.ifid;
        IDEX        = v.idex;
        EXMEM       = v.exmem;
        IDEXWrite   = v.idex_w;
        IDEXRegDst  = v.idex_rd;
        EXMEMWrite  = v.exmem_w;
        EXMEMRegDst = v.exmem_rd;
        PCSrc       = v.pcsrc;
        Predict     = v.predict;
        #1;
        checkOutput({name, ".PCStall"}, PCStall, v.exp_stall);
        checkOutput({name, ".MP"}, MP, v.exp_mp);
        if (v.chk_idex_dbg) begin
            checkOutput({name, ".debug2"}, debug2, dbg(v.exp_d2));
            checkOutput({name, ".debug3"}, debug3, dbg(v.exp_d3));
        end
        if (v.chk_exmem_dbg) begin
            checkOutput({name, ".debug1"}, debug1, dbg(v.exp_d1));
            checkOutput({name, ".debug4"}, debug4, dbg(v.exp_d4));
        end
        code_sb.push_back(int'(v.exp_code));
        @(posedge clock);
        #1;
        if (code_sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", name);
        end else begin
            exp_code = code_sb.pop_front();
            checkOutput({name, ".code"}, code, exp_code);
        end
    endtask

    initial begin
        vec_t v;
        reset = 1'b0;
        IFID = '0;
        IDEX = '0;
        EXMEM = '0;
        IDEXWrite = 1'b0;
        IDEXRegDst = 1'b0;
        EXMEMWrite = 1'b0;
        EXMEMRegDst = 1'b0;
        PCSrc = 1'b0;
        Predict = 1'b0;

        // Reset low with quiet inputs, then with a hazard and a mispredict present.
        v = mk(16'h0000, 16'h0000, 16'h0000, 4'b0000, 1'b0, 4'd0);
        v.rst_n = 1'b0;
        applyStimulus(v, "reset_quiet");
        v = mk(16'h1400, 16'h62A0, 16'h0000, 4'b1000, 1'b0, 4'd0);
        v.rst_n = 1'b0;
        v.pcsrc = 1'b1;
        applyStimulus(v, "reset_busy");

        vecs[0]  = mk(16'h0000, 16'h0000, 16'h0000, 4'b0000, 1'b0, 4'd0);
        vecs[1]  = mk(16'h1400, 16'h62A0, 16'h0000, 4'b1000, 1'b1, 4'd1);
        vecs[1].chk_idex_dbg = 1'b1;
        vecs[1].exp_d2 = 3'd5;
        vecs[1].exp_d3 = 3'b110;
        vecs[2]  = mk(16'h0100, 16'h0000, 16'h6103, 4'b0010, 1'b1, 4'd4);
        vecs[2].chk_exmem_dbg = 1'b1;
        vecs[2].exp_d1 = 3'd2;
        vecs[2].exp_d4 = 3'b101;
        vecs[3]  = mk(16'h0100, 16'h0000, 16'h6103, 4'b0000, 1'b0, 4'd0);
        vecs[4]  = mk(16'h0100, 16'h0000, 16'h6003, 4'b0010, 1'b0, 4'd0);
        vecs[5]  = mk(16'h0180, 16'h0030, 16'h0000, 4'b1100, 1'b1, 4'd2);
        vecs[6]  = mk(16'h1800, 16'h0000, 16'h0060, 4'b0011, 1'b1, 4'd3);
        vecs[7]  = mk(16'h1500, 16'h62A0, 16'h6103, 4'b1010, 1'b1, 4'd1);
        vecs[8]  = mk(16'h1680, 16'h62A0, 16'h0000, 4'b1000, 1'b1, 4'd1);
        vecs[9]  = mk(16'h1400, 16'h62A0, 16'h0000, 4'b1100, 1'b0, 4'd0);
        vecs[10] = mk(16'h0000, 16'h6000, 16'h0000, 4'b1000, 1'b0, 4'd0);

        for (int i = 0; i < 11; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Stall holds for as long as the hazard inputs do.
        for (int i = 0; i < 3; i++)
            applyStimulus(vecs[1], $sformatf("persist%0d", i));

        // Mispredict with a hazard present, one RECOVER cycle, then normal stalling.
        v = vecs[1];
        v.pcsrc = 1'b1;
        v.exp_stall = 1'b0;
        v.exp_mp = 1'b1;
        v.exp_code = 4'd8;
        applyStimulus(v, "mispredict");
        v.exp_mp = 1'b0;
        v.exp_code = 4'd9;
        applyStimulus(v, "recover");
        v.predict = 1'b1;
        v.exp_stall = 1'b1;
        v.exp_code = 4'd1;
        applyStimulus(v, "resume");

        // Reset taken while in RECOVER returns straight to NORMAL with code cleared.
        v = vecs[1];
        v.pcsrc = 1'b1;
        v.exp_stall = 1'b0;
        v.exp_mp = 1'b1;
        v.exp_code = 4'd8;
        applyStimulus(v, "mispredict2");
        v.rst_n = 1'b0;
        v.exp_mp = 1'b0;
        v.exp_code = 4'd0;
        applyStimulus(v, "reset_in_recover");
        applyStimulus(vecs[1], "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard controller for the 16-bit pipelined MIPS-style core. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers. It detects read-after-write hazards between the instruction in IF/ID and the writers in ID/EX or EX/MEM, and stalls the PC when one exists. It also flags branch mispredictions and reports a cause code plus debug taps.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- MP  out  1  misprediction flag, combinational.
- PCStall  out  1  hold PC and IF/ID, combinational.
- IFID  in  16  instruction in IF/ID.
- IDEX  in  16  instruction in ID/EX.
- EXMEM  in  16  instruction in EX/MEM.
- EXMEMWrite  in  1  EX/MEM instruction writes the register file.
- EXMEMRegDst  in  1  EX/MEM destination select: 1 = rd, 0 = rt.
- IDEXWrite  in  1  ID/EX instruction writes the register file.
- IDEXRegDst  in  1  ID/EX destination select: 1 = rd, 0 = rt.
- PCSrc  in  1  resolved branch outcome (1 = taken).
- Predict  in  1  prediction made for the resolving branch.
- code  out  4  registered hazard cause code.
- negclock  in  1  inverted clock; accepted for port compatibility, no logic uses it.
- debug1  out  3  EX/MEM destination register.
- debug2  out  3  ID/EX destination register.
- debug3  out  3  ID/EX hit vector {valid writer, rs match, rt match}.
- debug4  out  3  EX/MEM hit vector {valid writer, rs match, rt match}.

## Operation
- Instruction fields:
  - opcode [15:13]
  - rs [12:10]
  - rt [9:7]
  - rd [6:4]
- Destination of a stage: RegDst ? rd : rt.
- Valid writer: Write=1 and destination != 3'd0. r0 is never a hazard.
- Source comparison is conservative: both IFID.rs and IFID.rt are always compared, whatever the opcode.
- Hazard terms:
  - raw_idex = valid IDEX writer and (dst==rs or dst==rt).
  - raw_exmem = the same test against EX/MEM.
- mis = PCSrc XOR Predict.
- FSM states:
  - NORMAL
  - RECOVER
- Transitions:
  - NORMAL with mis=1 → RECOVER.
  - RECOVER → NORMAL unconditionally, after one cycle.
- In NORMAL:
  - MP = mis.
  - PCStall = (raw_idex or raw_exmem) and not mis. Misprediction has priority; wrong-path hazards are discarded.
- In RECOVER: MP=0 and PCStall=0, because wrong-path instructions are being flushed.
- Cause code (next_code), highest priority first:
  - 4'd9 when in RECOVER.
  - 4'd8 on mispredict.
  - 4'd1 IDEX hit on rs.
  - 4'd2 IDEX hit on rt.
  - 4'd3 EXMEM hit on rs.
  - 4'd4 EXMEM hit on rt.
  - 4'd0 none.
  - Values 5–7 and 10–15 are reserved and never produced.
- code <= next_code on every rising edge.

## Timing
- PCStall and MP are combinational from inputs and state, with zero-cycle latency.
- code lags its cause by exactly one clock.
- Reset sampled low at a rising edge gives state=NORMAL and code=4'd0.
- While reset is low, PCStall=0 and MP=0 combinationally.
- Reset asserted while in RECOVER aborts recovery and returns to NORMAL at that edge.
- IDEX and EXMEM hits simultaneously: PCStall=1, and code follows the priority list (IDEX wins).
- rs==rt matching the destination reports the rs code.
- Stall persists for as long as the hazard inputs persist; the block keeps no stall counter.

## Configuration
- HC_DEBUG_EN defined: debug1..debug4 are driven as specified.
- HC_DEBUG_EN undefined: debug1..debug4 are tied to 3'd0, and their compare logic is removed.
- PCStall, MP and code are identical in both builds.

## Test plan
- Reset low, all inputs 0 → PCStall=0, MP=0, code=0 after the edge.
- IDEX=16'b0110001010100000 (rt=5), IDEXWrite=1, IDEXRegDst=0, IFID=16'h1400 (rs=5) → PCStall=1 immediately, code=1 next cycle, debug2=5, debug3=3'b110.
- EXMEM=16'b0110000100000011 (rt=2), EXMEMWrite=1, IDEXWrite=0, IFID=16'h0100 (rt=2) → PCStall=1, code=4, debug1=2, debug4=3'b101.
- Same as the previous case but EXMEMWrite=0, or EXMEM destination=0 → PCStall=0, code=0.
- Hazard present with PCSrc=1, Predict=0 → MP=1, PCStall=0, code=8. Next cycle in RECOVER: MP=0, PCStall=0 even with the hazard still present; code=9, then normal operation resumes.
- Reset low during RECOVER → NORMAL and code=0 after the edge.
